// File: rtl/wb_protocol_checker.sv
// Passive Wishbone classic-cycle checker: flags protocol errors, counts errors and transfers.
// Optional build macro WBC_STABILITY_CHK_EN adds request capture registers and the E3 stability rule.
module wb_protocol_checker #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int TIMEOUT  = 16,
   parameter int ERRCNT_W = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic                wb_ack_i,
   input  logic [AW-1:0]       wb_adr_i,
   input  logic [DW/8-1:0]     wb_sel_i,
   input  logic [DW-1:0]       wb_dat_i,
   input  logic                clr_i,
   output logic [4:0]          err_flags_o,
   output logic                err_any_o,
   output logic [ERRCNT_W-1:0] err_cnt_o,
   output logic [15:0]         txn_cnt_o,
   output logic [2:0]          first_err_o,
   output logic                first_vld_o
);

   // state | meaning
   // IDLE  | no request outstanding
   // WAIT  | request held, waiting for ack, wait count below TIMEOUT
   // TOUT  | request timed out, waiting for late ack or drop
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_TOUT = 2'd2
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [15:0]         wait_cnt_q, wait_cnt_d;
   logic                first_q;
   logic [4:0]          flags_q, flags_d;
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [15:0]         txn_cnt_q, txn_cnt_d;
   logic [2:0]          first_err_q, first_err_d;
   logic                first_vld_q, first_vld_d;

   logic       req;
   logic       done;
   logic       cap_en;
   logic       e0, e1, e2, e3, e4;
   logic [4:0] fire;
   logic       fire_any;
   logic [2:0] fire_code;

   assign req = wb_cyc_i & wb_stb_i;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      done       = 1'b0;
      cap_en     = 1'b0;
      e2         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (wb_ack_i) begin
                  done = 1'b1;
               end else begin
                  state_d    = S_WAIT;
                  wait_cnt_d = 16'd1;
                  cap_en     = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (wb_ack_i) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               e2      = 1'b1;
               state_d = S_TOUT;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         S_TOUT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (wb_ack_i) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef WBC_STABILITY_CHK_EN
   logic [AW-1:0]   adr_q;
   logic            we_q;
   logic [DW/8-1:0] sel_q;
   logic [DW-1:0]   dat_q;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         adr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
      end else if (cap_en) begin
         adr_q <= wb_adr_i;
         we_q  <= wb_we_i;
         sel_q <= wb_sel_i;
         dat_q <= wb_dat_i;
      end
   end

   // Stability is judged only while the original request is still held in WAIT.
   assign e3 = (state_q == S_WAIT) & req &
               ((wb_adr_i != adr_q) | (wb_we_i != we_q) |
                (wb_sel_i != sel_q) | (wb_dat_i != dat_q));
`else
   logic unused_bus;
   assign unused_bus = ^{wb_adr_i, wb_we_i, wb_sel_i, wb_dat_i, cap_en};
   assign e3 = 1'b0;
`endif

   assign e0 = wb_stb_i & ~wb_cyc_i;
   assign e1 = wb_ack_i & ~req;
   assign e4 = first_q & (wb_cyc_i | wb_stb_i);

   assign fire     = {e4, e3, e2, e1, e0};
   assign fire_any = |fire;

   always_comb begin
      fire_code = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (fire[i]) fire_code = 3'(i);
      end
   end

   // A clear restarts everything from zero, but events in the clear cycle still land.
   always_comb begin
      flags_d     = (clr_i ? 5'd0 : flags_q) | fire;
      txn_cnt_d   = (clr_i ? 16'd0 : txn_cnt_q) + {15'd0, done};
      err_cnt_d   = clr_i ? '0 : err_cnt_q;
      first_err_d = clr_i ? 3'd0 : first_err_q;
      first_vld_d = clr_i ? 1'b0 : first_vld_q;
      if (fire_any && !(&err_cnt_d)) err_cnt_d = err_cnt_d + ERRCNT_W'(1);
      if (fire_any && !first_vld_d) begin
         first_vld_d = 1'b1;
         first_err_d = fire_code;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         first_q     <= 1'b1;
         flags_q     <= 5'd0;
         err_cnt_q   <= '0;
         txn_cnt_q   <= 16'd0;
         first_err_q <= 3'd0;
         first_vld_q <= 1'b0;
      end else begin
         first_q     <= 1'b0;
         flags_q     <= flags_d;
         err_cnt_q   <= err_cnt_d;
         txn_cnt_q   <= txn_cnt_d;
         first_err_q <= first_err_d;
         first_vld_q <= first_vld_d;
      end
   end

   assign err_flags_o = flags_q;
   assign err_any_o   = |flags_q;
   assign err_cnt_o   = err_cnt_q;
   assign txn_cnt_o   = txn_cnt_q;
   assign first_err_o = first_err_q;
   assign first_vld_o = first_vld_q;

endmodule

// File: doc/wb_protocol_checker.md
WB_PROTOCOL_CHECKER -- requirements
Module: wb_protocol_checker

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data bus width in bits.
REQ-002 The block SHALL have parameter AW, default 32, meaning the address bus width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, legal range 2..65535, meaning the maximum number of wait cycles before an ack is due.
REQ-004 The block SHALL have parameter ERRCNT_W, default 8, meaning the error counter width.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset (one clock; reset is synchronous and active-low)
- wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_i  in  1 each  monitored bus
- wb_adr_i  in  AW  monitored address
- wb_sel_i  in  DW/8  monitored byte selects
- wb_dat_i  in  DW  monitored write data
- clr_i  in  1  clears flags and counters
- err_flags_o  out  5  sticky flags, one per rule E0..E4
- err_any_o  out  1  OR of err_flags_o
- err_cnt_o  out  ERRCNT_W  saturating count of error cycles
- txn_cnt_o  out  16  wrapping count of completed transfers
- first_err_o  out  3  code of the first error since clear
- first_vld_o  out  1  first_err_o is valid

Function
REQ-006 The block SHALL be purely observational and SHALL never drive the monitored bus.
REQ-007 The block SHALL flag E0 in any cycle with wb_stb_i=1 and wb_cyc_i=0.
REQ-008 The block SHALL flag E1 in any cycle with wb_ack_i=1 and (wb_cyc_i & wb_stb_i)=0.
REQ-009 The block SHALL flag E2 in the cycle in which a request has been held for TIMEOUT consecutive cycles without ack.
REQ-010 The block SHALL flag E3 when adr, we, sel or dat changes while in WAIT (compiled per REQ-026).
REQ-011 The block SHALL flag E4 if cyc or stb is 1 in the first cycle after reset is released.
REQ-012 The FSM SHALL have the states IDLE, WAIT and TOUT.
REQ-013 In IDLE, cyc&stb&ack SHALL complete a transfer in zero wait and remain in IDLE.
REQ-014 In IDLE, cyc&stb&~ack SHALL move to WAIT, load wait counter = 1 and capture adr/we/sel/dat.
REQ-015 In WAIT, ack SHALL complete the transfer and return to IDLE.
REQ-016 In WAIT, cyc or stb dropping SHALL abort the transfer to IDLE without counting it and without flagging an error.
REQ-017 In WAIT, a wait count reaching TIMEOUT SHALL flag E2 and move to TOUT.
REQ-018 In TOUT, the FSM SHALL stay until ack or a cyc/stb drop, then return to IDLE; a late ack in TOUT SHALL count as a transfer, and E2 SHALL NOT re-fire.
REQ-019 txn_cnt_o SHALL increment by 1 per completed transfer and wrap from 0xFFFF to 0.
REQ-020 The error flags SHALL be registered and visible one cycle after the offending bus cycle; err_flags_o bits SHALL be sticky until clr_i or reset.
REQ-021 err_cnt_o SHALL increment by exactly 1 per cycle in which any error fires, regardless of how many fire, and SHALL saturate at 2^ERRCNT_W-1.
REQ-022 On the first error cycle after a clear, the block SHALL set first_vld_o and latch first_err_o = lowest-indexed firing rule; both SHALL hold until clr_i.
REQ-023 clr_i SHALL clear flags, counters and first_err in the next cycle and SHALL NOT affect the FSM; an error in the same cycle as clr_i SHALL win (flag set, err_cnt_o=1, first latched).

Reset
REQ-024 While wb_rst_n_i=0 at a clock edge, the FSM SHALL enter IDLE and all outputs and counters SHALL reset to 0.
REQ-025 Reset applied mid-transfer SHALL abandon the transfer without counting it; bus activity during reset SHALL be ignored.

Configuration
REQ-026 With macro WBC_STABILITY_CHK_EN defined, the capture registers and the E3 check SHALL be present; without it, those registers SHALL NOT be built and err_flags_o[3] SHALL be constant 0.

Verification
REQ-027 Zero-wait write (cyc=stb=ack=1, one cycle) -> txn_cnt_o=1, err_any_o=0.
REQ-028 stb=1 with cyc=0 for 1 cycle -> err_flags_o=5'b00001, err_cnt_o=1, first_err_o=0, first_vld_o=1.
REQ-029 TIMEOUT=4, request held for 6 cycles, then ack -> E2 set exactly once after the 4th wait cycle, err_cnt_o=1, txn_cnt_o=1.
REQ-030 Macro defined, wb_adr_i changes 0x100->0x104 in WAIT -> err_flags_o[3]=1; macro undefined -> err_flags_o[3]=0.
REQ-031 clr_i coinciding with a stray ack (E1) -> err_flags_o=5'b00010, err_cnt_o=1, first_err_o=1.
REQ-032 255 error cycles then 3 more with ERRCNT_W=8 -> err_cnt_o stays 255; reset mid-WAIT -> all outputs 0, FSM in IDLE.
